// File: rtl/src_arbiter_pkg.sv
// Shared constants for the sample-stream arbiter.
// Holds the config endpoint addresses that the arbiter decodes on the shared
// wr_en/wr_addr/wr_chan/wr_data bus. wr_chan selects the requester.
package src_arbiter_pkg;

  // Per-requester enable: en[wr_chan] <= wr_data[0]; writing 0 also flushes the hold.
  localparam logic [15:0] src_arb_en_addr      = 16'h0040;
  // Per-requester sticky overflow clear: ovf[wr_chan] <= 0.
  localparam logic [15:0] src_arb_ovf_clr_addr = 16'h0041;

endpackage

// File: rtl/src_arbiter_rr.sv
// Combinational round-robin pick.
// Grants the first asserted request strictly after ptr_i, wrapping NReq-1 -> 0.
// Ports:
//   req_i   - request vector
//   ptr_i   - index of the last grant (search starts one past it)
//   gnt_o   - one-hot grant
//   idx_o   - grant index (0 when nothing is granted)
//   valid_o - a grant was made
module src_arbiter_rr #(
  parameter int unsigned NReq = 4,
  parameter int unsigned WIdx = 2
) (
  input  logic [NReq-1:0] req_i,
  input  logic [WIdx-1:0] ptr_i,
  output logic [NReq-1:0] gnt_o,
  output logic [WIdx-1:0] idx_o,
  output logic            valid_o
);

  int unsigned     cand;
  logic [WIdx-1:0] cand_idx;

  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    // Offsets 1..NReq, so the last granted requester is considered last.
    for (int unsigned i = 1; i <= NReq; i++) begin
      cand     = (32'(ptr_i) + i) % NReq;
      cand_idx = WIdx'(cand);
      if (!valid_o && req_i[cand_idx]) begin
        valid_o = 1'b1;
        idx_o   = cand_idx;
      end
    end
    if (valid_o) begin
      gnt_o[idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/src_arbiter.sv
// Round-robin merge of N_REQ sample streams into one dv/src/data stream.
// Each requester has a one-deep holding register, an enable and a sticky
// overflow flag, all configured through the shared config write bus.
// Ports:
//   clk_in, rst_n_in        - clock, asynchronous active-low reset
//   req_dv_in/src/data      - per-requester sample strobe, packed ids and samples
//   ready_in                - downstream can take a word this cycle
//   wr_en/addr/chan/data    - config write bus (chan = requester index)
//   dv_out/src_out/data_out - registered merged sample (dv one cycle per grant)
//   grant_out               - requester that produced the current output
//   ovf_out                 - sticky overflow flags
module src_arbiter
  import src_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned W_REQ     = $clog2(N_REQ),
  parameter int unsigned W_SRC     = 5,
  parameter int unsigned W_DATA    = 18,
  parameter int unsigned W_WR_ADDR = 16,
  parameter int unsigned W_WR_CHAN = 16,
  parameter int unsigned W_WR_DATA = 48
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic [N_REQ-1:0]        req_dv_in,
  input  logic [N_REQ*W_SRC-1:0]  req_src_in,
  input  logic [N_REQ*W_DATA-1:0] req_data_in,
  input  logic                    ready_in,
  input  logic                    wr_en,
  input  logic [W_WR_ADDR-1:0]    wr_addr,
  input  logic [W_WR_CHAN-1:0]    wr_chan,
  input  logic [W_WR_DATA-1:0]    wr_data,
  output logic                    dv_out,
  output logic [W_SRC-1:0]        src_out,
  output logic [W_DATA-1:0]       data_out,
  output logic [W_REQ-1:0]        grant_out,
  output logic [N_REQ-1:0]        ovf_out
);

  logic [N_REQ-1:0]             hold_vld_q, hold_vld_d;
  logic [N_REQ-1:0][W_SRC-1:0]  hold_src_q, hold_src_d;
  logic [N_REQ-1:0][W_DATA-1:0] hold_data_q, hold_data_d;
  logic [N_REQ-1:0]             en_q, en_d;
  logic [N_REQ-1:0]             ovf_q, ovf_d;
  logic [W_REQ-1:0]             ptr_q, ptr_d;
  logic                         dv_q, dv_d;
  logic [W_SRC-1:0]             src_q, src_d;
  logic [W_DATA-1:0]            data_q, data_d;
  logic [W_REQ-1:0]             grant_q, grant_d;

  logic                         chan_ok;
  logic [W_REQ-1:0]             chan_idx;
  logic                         en_wr, clr_wr;
  logic [N_REQ-1:0]             arb_req, arb_gnt;
  logic [W_REQ-1:0]             arb_idx;
  logic                         arb_valid;
  logic                         unused_wr_data;

  // Only bit 0 of the config data is meaningful here.
  assign unused_wr_data = ^wr_data[W_WR_DATA-1:1];

  // Full-width check so out-of-range channels never alias onto a requester.
  assign chan_ok  = wr_chan < W_WR_CHAN'(N_REQ);
  assign chan_idx = wr_chan[W_REQ-1:0];
  assign en_wr    = wr_en & chan_ok & (wr_addr == W_WR_ADDR'(src_arb_en_addr));
  assign clr_wr   = wr_en & chan_ok & (wr_addr == W_WR_ADDR'(src_arb_ovf_clr_addr));

  // A stall freezes holds and pointer by presenting no requests at all.
  assign arb_req = hold_vld_q & {N_REQ{ready_in}};

  src_arbiter_rr #(
    .NReq (N_REQ),
    .WIdx (W_REQ)
  ) u_rr (
    .req_i   (arb_req),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_comb begin
    hold_vld_d  = hold_vld_q;
    hold_src_d  = hold_src_q;
    hold_data_d = hold_data_q;
    en_d        = en_q;
    ovf_d       = ovf_q;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (en_wr && chan_idx == W_REQ'(k)) begin
        en_d[k] = wr_data[0];
      end
      if (arb_gnt[k]) begin
        hold_vld_d[k] = 1'b0;
      end
      if (clr_wr && chan_idx == W_REQ'(k)) begin
        ovf_d[k] = 1'b0;
      end
      // Capture uses the enable as it stood before this edge's write.
      if (req_dv_in[k] && en_q[k]) begin
        if (!hold_vld_q[k] || arb_gnt[k]) begin
          hold_vld_d[k]  = 1'b1;
          hold_src_d[k]  = req_src_in[k*W_SRC +: W_SRC];
          hold_data_d[k] = req_data_in[k*W_DATA +: W_DATA];
        end else begin
          ovf_d[k] = 1'b1;  // overrides a coincident clear
        end
      end
      // Disabling flushes the hold; a grant on this edge still goes out.
      if (en_wr && chan_idx == W_REQ'(k) && !wr_data[0]) begin
        hold_vld_d[k] = 1'b0;
      end
    end
  end

  always_comb begin
    dv_d    = arb_valid;
    src_d   = src_q;
    data_d  = data_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    if (arb_valid) begin
      src_d   = hold_src_q[arb_idx];
      data_d  = hold_data_q[arb_idx];
      grant_d = arb_idx;
      ptr_d   = arb_idx;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hold_vld_q  <= '0;
      hold_src_q  <= '0;
      hold_data_q <= '0;
      en_q        <= '0;
      ovf_q       <= '0;
      ptr_q       <= W_REQ'(N_REQ - 1);  // requester 0 wins first
      dv_q        <= 1'b0;
      src_q       <= '0;
      data_q      <= '0;
      grant_q     <= '0;
    end else begin
      hold_vld_q  <= hold_vld_d;
      hold_src_q  <= hold_src_d;
      hold_data_q <= hold_data_d;
      en_q        <= en_d;
      ovf_q       <= ovf_d;
      ptr_q       <= ptr_d;
      dv_q        <= dv_d;
      src_q       <= src_d;
      data_q      <= data_d;
      grant_q     <= grant_d;
    end
  end

  assign dv_out    = dv_q;
  assign src_out   = src_q;
  assign data_out  = data_q;
  assign grant_out = grant_q;
  assign ovf_out   = ovf_q;

endmodule

// File: tb/tb_src_arbiter.sv
// Self-checking bench for src_arbiter: expected words are queued as stimulus
// is driven and compared in order whenever dv_out is seen.
module tb_src_arbiter;
  import src_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int WS = 5;
  localparam int WD = 18;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req_dv;
  logic [N*WS-1:0] req_src;
  logic [N*WD-1:0] req_data;
  logic          ready;
  logic          wr_en;
  logic [15:0]   wr_addr;
  logic [15:0]   wr_chan;
  logic [47:0]   wr_data;
  logic          dv_out;
  logic [WS-1:0] src_out;
  logic [WD-1:0] data_out;
  logic [1:0]    grant_out;
  logic [N-1:0]  ovf_out;

  src_arbiter dut (
    .clk_in      (clk),
    .rst_n_in    (rst_n),
    .req_dv_in   (req_dv),
    .req_src_in  (req_src),
    .req_data_in (req_data),
    .ready_in    (ready),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_chan     (wr_chan),
    .wr_data     (wr_data),
    .dv_out      (dv_out),
    .src_out     (src_out),
    .data_out    (data_out),
    .grant_out   (grant_out),
    .ovf_out     (ovf_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [WS-1:0] src;
    logic [WD-1:0] data;
    logic [1:0]    grant;
  } exp_t;

  typedef struct {
    int            k;
    logic [WS-1:0] src;
    logic [WD-1:0] data;
  } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b1;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard consumer, sampled away from the rising edge.
  always @(negedge clk) begin
    if (mon_en && rst_n && dv_out) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_dv: got grant=%0d src=%0d data=0x%0h want no output",
                 grant_out, src_out, data_out);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_grant", 48'(grant_out), 48'(mon_e.grant));
        chk("out_src", 48'(src_out), 48'(mon_e.src));
        chk("out_data", 48'(data_out), 48'(mon_e.data));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [15:0] addr, input logic [15:0] chan, input logic [47:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_chan = chan;
    wr_data = data;
    tick(1);
    wr_en   = 1'b0;
  endtask

  task automatic set_word(input int k, input logic [WS-1:0] s, input logic [WD-1:0] d);
    req_src[k*WS +: WS]  = s;
    req_data[k*WD +: WD] = d;
  endtask

  task automatic pulse(input logic [N-1:0] m);
    req_dv = m;
    tick(1);
    req_dv = '0;
  endtask

  task automatic push(input int g, input logic [WS-1:0] s, input logic [WD-1:0] d);
    exp_t e;
    e.grant = 2'(g);
    e.src   = s;
    e.data  = d;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      tick(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: got %0d words pending want 0", name, exp_q.size());
      exp_q.delete();
    end
    tick(2);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic enable_all();
    for (int k = 0; k < N; k++) cfg(src_arb_en_addr, 16'(k), 48'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog");
  end

  vec_t vt[6];

  initial begin
    rst_n    = 1'b0;
    req_dv   = '0;
    req_src  = '0;
    req_data = '0;
    ready    = 1'b1;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_chan  = '0;
    wr_data  = '0;

    // Reset state
    tick(2);
    chk("rst_dv", 48'(dv_out), 48'd0);
    chk("rst_src", 48'(src_out), 48'd0);
    chk("rst_data", 48'(data_out), 48'd0);
    chk("rst_grant", 48'(grant_out), 48'd0);
    chk("rst_ovf", 48'(ovf_out), 48'd0);
    rst_n = 1'b1;
    tick(1);

    // Single requester, two-edge latency
    cfg(src_arb_en_addr, 16'd0, 48'd1);
    set_word(0, 5'd3, 18'h1ABCD);
    push(0, 5'd3, 18'h1ABCD);
    req_dv = 4'b0001;
    @(posedge clk);
    #1 req_dv = '0;
    @(negedge clk) chk("lat_capture_edge", 48'(dv_out), 48'd0);
    @(negedge clk) chk("lat_next_edge", 48'(dv_out), 48'd1);
    tick(1);
    drain("t1_drain");

    // Table of isolated single-requester words
    enable_all();
    vt[0] = '{0, 5'd1,  18'h00011};
    vt[1] = '{2, 5'd7,  18'h2A5A5};
    vt[2] = '{1, 5'd31, 18'h3FFFF};
    vt[3] = '{3, 5'd0,  18'h00000};
    vt[4] = '{3, 5'd12, 18'h15555};
    vt[5] = '{1, 5'd19, 18'h0F0F0};
    for (int i = 0; i < 6; i++) begin
      set_word(vt[i].k, vt[i].src, vt[i].data);
      push(vt[i].k, vt[i].src, vt[i].data);
      pulse(4'(1 << vt[i].k));
      tick(2);
    end
    drain("table_drain");
    chk("table_ovf", 48'(ovf_out), 48'd0);

    // Continuous 1111 flood: strict rotation from req0, everyone overflows
    do_reset();
    enable_all();
    for (int k = 0; k < N; k++) set_word(k, 5'(8 + k), 18'(18'h02000 + k));
    for (int i = 0; i < 15; i++) push(i % 4, 5'(8 + i % 4), 18'(18'h02000 + i % 4));
    req_dv = 4'b1111;
    tick(12);
    req_dv = '0;
    drain("flood_drain");
    chk("flood_ovf", 48'(ovf_out), 48'hF);
    for (int k = 0; k < N; k++) cfg(src_arb_ovf_clr_addr, 16'(k), 48'd0);
    chk("flood_ovf_clr", 48'(ovf_out), 48'd0);

    // Stall: one word each, extra req2 overflows, then back-to-back burst
    do_reset();
    enable_all();
    ready = 1'b0;
    for (int k = 0; k < N; k++) begin
      set_word(k, 5'(16 + k), 18'(18'h30000 + k));
      push(k, 5'(16 + k), 18'(18'h30000 + k));
    end
    pulse(4'b1111);
    set_word(2, 5'd30, 18'h3FFFF);
    pulse(4'b0100);
    tick(5);
    chk("stall_ovf", 48'(ovf_out), 48'h4);
    chk("stall_dv", 48'(dv_out), 48'd0);
    ready = 1'b1;
    @(posedge clk);
    repeat (4) @(negedge clk) chk("burst_dv", 48'(dv_out), 48'd1);
    tick(1);
    drain("stall_drain");

    // Disabled requester is dropped silently
    cfg(src_arb_en_addr, 16'd1, 48'd0);
    set_word(1, 5'd9, 18'h01111);
    pulse(4'b0010);
    tick(3);
    chk("dis_ovf", 48'(ovf_out), 48'h4);
    // Out-of-range channels must not alias onto req3 / req2
    cfg(src_arb_en_addr, 16'd7, 48'd0);
    cfg(src_arb_ovf_clr_addr, 16'd6, 48'd0);
    chk("inv_clr_ovf", 48'(ovf_out), 48'h4);
    set_word(3, 5'd21, 18'h0BEEF);
    push(3, 5'd21, 18'h0BEEF);
    pulse(4'b1000);
    drain("inv_en_drain");
    cfg(src_arb_en_addr, 16'd1, 48'd1);
    set_word(1, 5'd10, 18'h02222);
    push(1, 5'd10, 18'h02222);
    pulse(4'b0010);
    drain("reen_drain");

    // Overflow set beats a coincident clear
    cfg(src_arb_ovf_clr_addr, 16'd2, 48'd0);
    chk("clr2_ovf", 48'(ovf_out), 48'd0);
    ready = 1'b0;
    set_word(3, 5'd22, 18'h12345);
    push(3, 5'd22, 18'h12345);
    pulse(4'b1000);
    set_word(3, 5'd23, 18'h00BAD);
    pulse(4'b1000);
    chk("ovf3_set", 48'(ovf_out), 48'h8);
    wr_en   = 1'b1;
    wr_addr = src_arb_ovf_clr_addr;
    wr_chan = 16'd3;
    req_dv  = 4'b1000;
    tick(1);
    wr_en  = 1'b0;
    req_dv = '0;
    chk("ovf_race", 48'(ovf_out), 48'h8);
    cfg(src_arb_ovf_clr_addr, 16'd3, 48'd0);
    chk("ovf_plain_clr", 48'(ovf_out), 48'd0);
    ready = 1'b1;
    drain("race_drain");

    // Disabling a full hold discards its word
    ready = 1'b0;
    set_word(0, 5'd24, 18'h0DEAD);
    pulse(4'b0001);
    cfg(src_arb_en_addr, 16'd0, 48'd0);
    ready = 1'b1;
    tick(4);
    chk("dis_flush_dv", 48'(dv_out), 48'd0);
    cfg(src_arb_en_addr, 16'd0, 48'd1);

    // Asynchronous reset mid-burst
    mon_en = 1'b0;
    req_dv = 4'b1111;
    tick(6);
    chk("pre_rst_ovf", 48'(ovf_out), 48'hF);
    chk("pre_rst_dv", 48'(dv_out), 48'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_dv", 48'(dv_out), 48'd0);
    chk("async_rst_ovf", 48'(ovf_out), 48'd0);
    chk("async_rst_data", 48'(data_out), 48'd0);
    req_dv = '0;
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
    tick(1);
    cfg(src_arb_en_addr, 16'd3, 48'd1);
    cfg(src_arb_en_addr, 16'd0, 48'd1);
    set_word(0, 5'd25, 18'h00A0A);
    set_word(3, 5'd26, 18'h00B0B);
    push(0, 5'd25, 18'h00A0A);
    push(3, 5'd26, 18'h00B0B);
    pulse(4'b1001);
    drain("post_rst_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
